alp_step_seq: RTL and testbench

ALP_STEP_SEQ -- requirements
Module: alp_step_seq

---
 rtl/alp_step_seq.sv | 161 ++++++++++++++++
 tb/tb_alp_step_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alp_step_seq.sv
// Microsequencer for ALP bit-slice shift-and-add multiply and non-restoring divide.
// Every output is registered; the slice status flags select the control word latched at the next edge.
module alp_step_seq #(
    parameter logic [9:0] OPC_NOP   = 10'h000,
    parameter logic [9:0] OPC_LOAD  = 10'h001,
    parameter logic [9:0] OPC_ADDSH = 10'h002,
    parameter logic [9:0] OPC_SH    = 10'h003,
    parameter logic [9:0] OPC_SUBSH = 10'h004,
    parameter logic [9:0] OPC_ADD   = 10'h005
) (
    input  logic       clk_h,
    input  logic       reset_h,
    input  logic       start_h,
    input  logic       abort_h,
    input  logic       mode_h,
    input  logic [5:0] count_h,
    input  logic       q_lsb_h,
    input  logic       a_sign_h,
    input  logic       z_h,
    input  logic       v_h,
    output logic [9:0] opc_h,
    output logic [1:0] shf_l,
    output logic       cyin_l,
    output logic       busy_h,
    output logic       done_h,
    output logic       ovf_h,
    output logic       zero_h
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_FIX,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [9:0] opc;
        logic [1:0] shf;
        logic       cyin;
        logic       busy;
        logic       done;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{opc: OPC_NOP,  shf: 2'b11, cyin: 1'b1, busy: 1'b0, done: 1'b0};
    localparam ctl_t CTL_LOAD = '{opc: OPC_LOAD, shf: 2'b11, cyin: 1'b1, busy: 1'b1, done: 1'b0};
    localparam ctl_t CTL_DONE = '{opc: OPC_NOP,  shf: 2'b11, cyin: 1'b1, busy: 1'b0, done: 1'b1};

    state_t     state_q;
    ctl_t       ctl_q;
    logic [5:0] cnt_q;
    logic       mode_q;
    logic       ovf_q;
    logic       zero_q;

    ctl_t       step_ctl;
    ctl_t       fix_ctl;
    logic       last_step;

    // Control words for the next STEP/FIX cycle, chosen from this cycle's slice flags.
    always_comb begin
        // NOTE: every field gets a default first so no path can infer a latch.
        step_ctl = '{opc: OPC_SH, shf: 2'b01, cyin: 1'b1, busy: 1'b1, done: 1'b0};
        if (!mode_q) begin
            step_ctl.opc = q_lsb_h ? OPC_ADDSH : OPC_SH;
        end else begin
            step_ctl.shf = 2'b10;
            if (a_sign_h) begin
                step_ctl.opc  = OPC_ADDSH;
            end else begin
                step_ctl.opc  = OPC_SUBSH;
                step_ctl.cyin = 1'b0;
            end
        end

        fix_ctl     = '{opc: OPC_NOP, shf: 2'b11, cyin: 1'b1, busy: 1'b1, done: 1'b0};
        fix_ctl.opc = a_sign_h ? OPC_ADD : OPC_NOP;
    end

    // A zero count can only reach STEP through a fault; treat it as the last step too.
    assign last_step = (cnt_q <= 6'd1);

    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state_q <= S_IDLE;
            ctl_q   <= CTL_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (abort_h) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= S_IDLE;
            ctl_q   <= CTL_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_h) begin
                        ovf_q <= 1'b0;
                        if (count_h != 6'd0) begin
                            mode_q  <= mode_h;
                            cnt_q   <= count_h;
                            state_q <= S_LOAD;
                            ctl_q   <= CTL_LOAD;
                        end else begin
                            zero_q  <= z_h;
                            state_q <= S_DONE;
                            ctl_q   <= CTL_DONE;
                        end
                    end
                end

                S_LOAD: begin
                    state_q <= S_STEP;
                    ctl_q   <= step_ctl;
                end

                S_STEP: begin
                    cnt_q <= cnt_q - 6'd1;
                    ovf_q <= ovf_q | v_h;
                    if (!last_step) begin
                        ctl_q <= step_ctl;
                    end else if (mode_q) begin
                        state_q <= S_FIX;
                        ctl_q   <= fix_ctl;
                    end else begin
                        zero_q  <= z_h;
                        state_q <= S_DONE;
                        ctl_q   <= CTL_DONE;
                    end
                end

                S_FIX: begin
                    zero_q  <= z_h;
                    state_q <= S_DONE;
                    ctl_q   <= CTL_DONE;
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    ctl_q   <= CTL_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    ctl_q   <= CTL_IDLE;
                end
            endcase
        end
    end

    assign opc_h  = ctl_q.opc;
    assign shf_l  = ctl_q.shf;
    assign cyin_l = ctl_q.cyin;
    assign busy_h = ctl_q.busy;
    assign done_h = ctl_q.done;
    assign ovf_h  = ovf_q;
    assign zero_h = zero_q;

endmodule

// File: tb/tb_alp_step_seq.sv
// Directed bench for alp_step_seq: a per-cycle vector table plus hand-written abort,
// reset and long-count sequences.
module tb_alp_step_seq;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    localparam logic [9:0] NOP = 10'h000;
    localparam logic [9:0] LD  = 10'h001;
    localparam logic [9:0] ASH = 10'h002;
    localparam logic [9:0] SH  = 10'h003;
    localparam logic [9:0] SSH = 10'h004;
    localparam logic [9:0] ADD = 10'h005;

    logic       clk_h;
    logic       reset_h;
    logic       start_h;
    logic       abort_h;
    logic       mode_h;
    logic [5:0] count_h;
    logic       q_lsb_h;
    logic       a_sign_h;
    logic       z_h;
    logic       v_h;
    logic [9:0] opc_h;
    logic [1:0] shf_l;
    logic       cyin_l;
    logic       busy_h;
    logic       done_h;
    logic       ovf_h;
    logic       zero_h;

    logic [16:0] obs;
    assign obs = {opc_h, shf_l, cyin_l, busy_h, done_h, ovf_h, zero_h};

    int total = 0;
    int bad   = 0;

    alp_step_seq dut (
        .clk_h   (clk_h),
        .reset_h (reset_h),
        .start_h (start_h),
        .abort_h (abort_h),
        .mode_h  (mode_h),
        .count_h (count_h),
        .q_lsb_h (q_lsb_h),
        .a_sign_h(a_sign_h),
        .z_h     (z_h),
        .v_h     (v_h),
        .opc_h   (opc_h),
        .shf_l   (shf_l),
        .cyin_l  (cyin_l),
        .busy_h  (busy_h),
        .done_h  (done_h),
        .ovf_h   (ovf_h),
        .zero_h  (zero_h)
    );

    initial clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    typedef struct packed {
        logic       start;
        logic       abort;
        logic       mode;
        logic [5:0] count;
        logic       q;
        logic       a;
        logic       z;
        logic       v;
        logic [9:0] opc;
        logic [1:0] shf;
        logic       cyin;
        logic       busy;
        logic       done;
        logic       ovf;
        logic       zero;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic s, ab, m, input logic [5:0] c,
                                input logic q, a, z, v,
                                input logic [9:0] o, input logic [1:0] sh,
                                input logic cy, bu, dn, ov, ze);
        vec_t r;
        r.start = s;  r.abort = ab; r.mode = m;  r.count = c;
        r.q     = q;  r.a     = a;  r.z    = z;  r.v     = v;
        r.opc   = o;  r.shf   = sh; r.cyin = cy; r.busy  = bu;
        r.done  = dn; r.ovf   = ov; r.zero = ze;
        return r;
    endfunction

    function automatic logic [16:0] ex(input logic [9:0] o, input logic [1:0] sh,
                                       input logic cy, bu, dn, ov, ze);
        return {o, sh, cy, bu, dn, ov, ze};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %05h expected %05h", name, act, expv);
        end
    endtask

    task automatic drive(input logic s, ab, m, input logic [5:0] c, input logic q, a, z, v);
        start_h  = s;
        abort_h  = ab;
        mode_h   = m;
        count_h  = c;
        q_lsb_h  = q;
        a_sign_h = a;
        z_h      = z;
        v_h      = v;
    endtask

    task automatic idle_in();
        drive(L, L, L, 6'd0, L, L, L, L);
    endtask

    task automatic adv();
        @(posedge clk_h);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int busy_n;
        int dn_seen;

        // Multiply, count 4, q_lsb 1,0,1,1 (each sampled one cycle before its opcode shows).
        vecs[0]  = mk(H,L,L,6'd4, L,L,L,L, NOP,2'b11,H,L,L,L,L);
        vecs[1]  = mk(L,L,L,6'd0, H,L,L,L, LD ,2'b11,H,H,L,L,L);
        vecs[2]  = mk(L,L,L,6'd0, L,L,L,L, ASH,2'b01,H,H,L,L,L);
        vecs[3]  = mk(L,L,L,6'd0, H,L,L,L, SH ,2'b01,H,H,L,L,L);
        vecs[4]  = mk(L,L,L,6'd0, H,L,L,L, ASH,2'b01,H,H,L,L,L);
        vecs[5]  = mk(L,L,L,6'd0, L,L,H,L, ASH,2'b01,H,H,L,L,L);
        vecs[6]  = mk(L,L,L,6'd0, L,L,L,L, NOP,2'b11,H,L,H,L,H);
        vecs[7]  = mk(L,L,L,6'd0, L,L,L,L, NOP,2'b11,H,L,L,L,H);
        // Divide, count 3, a_sign 0,1,0 then 1 deciding the FIX add.
        vecs[8]  = mk(H,L,H,6'd3, L,L,L,L, NOP,2'b11,H,L,L,L,H);
        vecs[9]  = mk(L,L,L,6'd0, L,L,L,L, LD ,2'b11,H,H,L,L,H);
        vecs[10] = mk(L,L,L,6'd0, L,H,L,L, SSH,2'b10,L,H,L,L,H);
        vecs[11] = mk(L,L,L,6'd0, L,L,L,L, ASH,2'b10,H,H,L,L,H);
        vecs[12] = mk(L,L,L,6'd0, L,H,L,L, SSH,2'b10,L,H,L,L,H);
        vecs[13] = mk(L,L,L,6'd0, L,L,L,L, ADD,2'b11,H,H,L,L,H);
        vecs[14] = mk(L,L,L,6'd0, L,L,L,L, NOP,2'b11,H,L,H,L,L);
        vecs[15] = mk(L,L,L,6'd0, L,L,L,L, NOP,2'b11,H,L,L,L,L);
        // Zero count goes straight to DONE; start during DONE is dropped.
        vecs[16] = mk(H,L,L,6'd0, L,L,H,L, NOP,2'b11,H,L,L,L,L);
        vecs[17] = mk(H,L,L,6'd2, L,L,H,L, NOP,2'b11,H,L,H,L,H);
        vecs[18] = mk(L,L,L,6'd0, L,L,L,L, NOP,2'b11,H,L,L,L,H);
        // Multiply, count 5, v pulse in step 2; ovf sticky until the next start.
        vecs[19] = mk(H,L,L,6'd5, L,L,L,L, NOP,2'b11,H,L,L,L,H);
        vecs[20] = mk(L,L,L,6'd0, L,L,L,L, LD ,2'b11,H,H,L,L,H);
        vecs[21] = mk(L,L,L,6'd0, L,L,L,L, SH ,2'b01,H,H,L,L,H);
        vecs[22] = mk(L,L,L,6'd0, L,L,L,H, SH ,2'b01,H,H,L,L,H);
        vecs[23] = mk(L,L,L,6'd0, L,L,L,L, SH ,2'b01,H,H,L,H,H);
        vecs[24] = mk(L,L,L,6'd0, L,L,L,L, SH ,2'b01,H,H,L,H,H);
        vecs[25] = mk(L,L,L,6'd0, L,L,L,L, SH ,2'b01,H,H,L,H,H);
        vecs[26] = mk(L,L,L,6'd0, L,L,L,L, NOP,2'b11,H,L,H,H,L);
        vecs[27] = mk(L,L,L,6'd0, L,L,L,L, NOP,2'b11,H,L,L,H,L);
        vecs[28] = mk(H,L,L,6'd1, L,L,L,L, NOP,2'b11,H,L,L,H,L);
        vecs[29] = mk(L,L,L,6'd0, H,L,L,L, LD ,2'b11,H,H,L,L,L);
        vecs[30] = mk(L,L,L,6'd0, L,L,L,L, ASH,2'b01,H,H,L,L,L);
        vecs[31] = mk(L,L,L,6'd0, L,L,L,L, NOP,2'b11,H,L,H,L,L);

        idle_in();
        reset_h = 1'b1;
        repeat (2) @(posedge clk_h);
        #1;
        check("reset_outputs", obs, ex(NOP,2'b11,H,L,L,L,L));
        reset_h = 1'b0;

        // Row 0 start lands on the first edge after reset release.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].start, vecs[i].abort, vecs[i].mode, vecs[i].count,
                  vecs[i].q, vecs[i].a, vecs[i].z, vecs[i].v);
            @(negedge clk_h);
            check($sformatf("row%0d", i), obs,
                  ex(vecs[i].opc, vecs[i].shf, vecs[i].cyin, vecs[i].busy,
                     vecs[i].done, vecs[i].ovf, vecs[i].zero));
            adv();
        end

        // Abort in step 2; a start during STEP must not disturb the run.
        drive(H,L,L,6'd5, L,L,L,L); @(negedge clk_h); adv();
        idle_in();                   @(negedge clk_h); adv();
        drive(H,L,H,6'd1, L,L,L,H);  @(negedge clk_h);
        check("abort_step1", obs, ex(SH,2'b01,H,H,L,L,L));
        adv();
        drive(L,H,L,6'd0, L,L,L,L);  @(negedge clk_h);
        check("abort_step2", obs, ex(SH,2'b01,H,H,L,H,L));
        adv();
        idle_in();                   @(negedge clk_h);
        check("abort_idle", obs, ex(NOP,2'b11,H,L,L,H,L));
        adv();
        dn_seen = 0;
        for (int k = 0; k < 6; k++) begin
            idle_in(); @(negedge clk_h);
            if (done_h) dn_seen++;
            adv();
        end
        check("abort_no_done", 17'(dn_seen), 17'd0);
        check("abort_ovf_held", 17'(ovf_h), 17'd1);

        // Fresh start after abort, multiply count 2.
        drive(H,L,L,6'd2, L,L,L,L);  @(negedge clk_h); adv();
        idle_in();                   @(negedge clk_h);
        check("restart_load", obs, ex(LD,2'b11,H,H,L,L,L));
        adv();
        idle_in(); @(negedge clk_h); adv();
        idle_in(); @(negedge clk_h); adv();
        idle_in(); @(negedge clk_h);
        check("restart_done", obs, ex(NOP,2'b11,H,L,H,L,L));
        adv();

        // Abort outranks start in IDLE.
        drive(H,H,L,6'd3, L,L,L,L);  @(negedge clk_h); adv();
        idle_in();                   @(negedge clk_h);
        check("abort_beats_start", obs, ex(NOP,2'b11,H,L,L,L,L));
        adv();

        // Abort during DONE keeps the pulse already there.
        drive(H,L,L,6'd0, L,L,H,L);  @(negedge clk_h); adv();
        drive(L,H,L,6'd0, L,L,L,L);  @(negedge clk_h);
        check("abort_in_done_pulse", obs, ex(NOP,2'b11,H,L,H,L,H));
        adv();
        idle_in();                   @(negedge clk_h);
        check("after_abort_done", obs, ex(NOP,2'b11,H,L,L,L,H));
        adv();

        // Count 63: LOAD + 63 steps busy, done at t+65.
        drive(H,L,L,6'd63, L,L,L,L); @(negedge clk_h); adv();
        lat = -1;
        busy_n = 0;
        for (int k = 1; k <= 80 && lat < 0; k++) begin
            idle_in(); @(negedge clk_h);
            if (done_h) lat = k;
            else if (busy_h) busy_n++;
            adv();
        end
        check("cnt63_latency", 17'(lat), 17'd65);
        check("cnt63_busy_cycles", 17'(busy_n), 17'd64);

        // Reset between edges in STEP, with ovf and zero both set beforehand.
        drive(H,L,L,6'd0, L,L,H,L);  @(negedge clk_h); adv();
        idle_in();                   @(negedge clk_h); adv();
        drive(H,L,L,6'd6, L,L,L,L);  @(negedge clk_h); adv();
        idle_in();                   @(negedge clk_h); adv();
        drive(L,L,L,6'd0, L,L,L,H);  @(negedge clk_h); adv();
        idle_in();                   @(negedge clk_h);
        check("pre_reset_flags", 17'({ovf_h, zero_h, busy_h}), 17'b111);
        #1 reset_h = 1'b1;
        #1 check("reset_mid_step", obs, ex(NOP,2'b11,H,L,L,L,L));
        #1 reset_h = 1'b0;
        adv();
        dn_seen = 0;
        busy_n  = 0;
        for (int k = 0; k < 8; k++) begin
            idle_in(); @(negedge clk_h);
            if (done_h) dn_seen++;
            if (busy_h) busy_n++;
            adv();
        end
        check("reset_no_done", 17'(dn_seen), 17'd0);
        check("reset_no_busy", 17'(busy_n), 17'd0);

        // Divide count 1 with a positive remainder: FIX issues NOP, done at t+4.
        drive(H,L,H,6'd1, L,L,L,L);  @(negedge clk_h); adv();
        idle_in();                   @(negedge clk_h);
        check("div1_load", obs, ex(LD,2'b11,H,H,L,L,L));
        adv();
        idle_in();                   @(negedge clk_h);
        check("div1_step", obs, ex(SSH,2'b10,L,H,L,L,L));
        adv();
        idle_in();                   @(negedge clk_h);
        check("div1_fix", obs, ex(NOP,2'b11,H,H,L,L,L));
        adv();
        idle_in();                   @(negedge clk_h);
        check("div1_done", obs, ex(NOP,2'b11,H,L,H,L,L));
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
